// File: rtl/systolic_pkg.sv
// Shared definitions for the 3x3 FP8 systolic multiplier: operand geometry,
// FP8 field layout and the operand feeder state encoding.
package systolic_pkg;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned N        = 3;

    localparam int unsigned SIGN_BIT = 7;
    localparam int unsigned EXP_MSB  = 6;
    localparam int unsigned EXP_LSB  = 4;
    localparam int unsigned MAN_W    = 4;
    localparam int unsigned EXP_BIAS = 3;
    localparam logic [7:0]  FP8_ONE  = 8'h30;

    typedef enum logic [2:0] {IDLE, LOAD, FEED, FLUSH, DONE} feeder_state_e;

    // Counter width for a counter that must hold values 0..range-1, never below 1 bit.
    function automatic int unsigned cnt_w(input int unsigned range);
        return (range <= 1) ? 1 : $clog2(range);
    endfunction
endpackage

// File: rtl/systolic_operand_feeder_if.sv
// Control and operand bus between a matrix source and the systolic operand feeder.
interface systolic_operand_feeder_if import systolic_pkg::*; #(
    parameter int unsigned DATA_W = systolic_pkg::DATA_W,
    parameter int unsigned N      = systolic_pkg::N
);
    logic                  start;
    logic                  stall;
    logic [N*N*DATA_W-1:0] a_mat;
    logic [N*N*DATA_W-1:0] b_mat;
    logic [N*DATA_W-1:0]   a_west;
    logic [N*DATA_W-1:0]   b_north;
    logic                  pe_clear;
    logic                  feed_valid;
    logic                  busy;
    logic                  done;

    modport master (
        output start, stall, a_mat, b_mat,
        input  a_west, b_north, pe_clear, feed_valid, busy, done
    );

    modport slave (
        input  start, stall, a_mat, b_mat,
        output a_west, b_north, pe_clear, feed_valid, busy, done
    );
endinterface

// File: rtl/systolic_skew_mux.sv
// Selects the diagonally skewed operand for one array lane at step t:
// row mode returns M[lane][t-lane], column mode returns M[t-lane][lane], else 0.
module systolic_skew_mux import systolic_pkg::*; #(
    parameter int unsigned DATA_W   = systolic_pkg::DATA_W,
    parameter int unsigned N        = systolic_pkg::N,
    parameter bit          COL_MODE = 1'b0,
    parameter int unsigned STEP_W   = cnt_w(2*N-1),
    parameter int unsigned LANE_W   = cnt_w(N)
) (
    input  logic [N*N*DATA_W-1:0] mat,
    input  logic [STEP_W-1:0]     step,
    input  logic [LANE_W-1:0]     lane,
    output logic [DATA_W-1:0]     operand
);
    int k;
    int idx;

    always_comb begin
        operand = '0;
        k       = int'(step) - int'(lane);
        idx     = 0;
        if (k >= 0 && k < int'(N)) begin
            idx     = COL_MODE ? (k * int'(N) + int'(lane)) : (int'(lane) * int'(N) + k);
            operand = mat[idx*DATA_W +: DATA_W];
        end
    end
endmodule

// File: rtl/systolic_operand_feeder.sv
// Latches A/B operand matrices and streams them skewed into the west and north
// edges of an NxN systolic array, followed by flush cycles and a done pulse.
module systolic_operand_feeder import systolic_pkg::*; #(
    parameter int unsigned DATA_W       = systolic_pkg::DATA_W,
    parameter int unsigned N            = systolic_pkg::N,
    parameter int unsigned FLUSH_CYCLES = 3
) (
    input logic                     clk,
    input logic                     reset,
    systolic_operand_feeder_if.slave bus
);
    localparam int unsigned STEP_W  = cnt_w(2*N-1);
    localparam int unsigned FLUSH_W = cnt_w(FLUSH_CYCLES+1);
    localparam int unsigned LANE_W  = cnt_w(N);
    localparam logic [STEP_W-1:0]  LAST_STEP  = STEP_W'(2*N-2);
    localparam logic [FLUSH_W-1:0] LAST_FLUSH = FLUSH_W'((FLUSH_CYCLES == 0) ? 0 : FLUSH_CYCLES-1);

    feeder_state_e         state;
    logic [STEP_W-1:0]     step;
    logic [STEP_W-1:0]     mux_step;
    logic [FLUSH_W-1:0]    flush_cnt;
    logic [N*N*DATA_W-1:0] a_lat;
    logic [N*N*DATA_W-1:0] b_lat;
    logic [N*DATA_W-1:0]   a_skew;
    logic [N*DATA_W-1:0]   b_skew;

    // The muxes select the step about to be registered, so outputs line up with step.
    assign mux_step = (state == FEED) ? step + 1'b1 : '0;

    for (genvar i = 0; i < N; i++) begin : g_lane
        systolic_skew_mux #(
            .DATA_W(DATA_W), .N(N), .COL_MODE(1'b0), .STEP_W(STEP_W), .LANE_W(LANE_W)
        ) u_a_mux (
            .mat(a_lat), .step(mux_step), .lane(LANE_W'(i)), .operand(a_skew[i*DATA_W +: DATA_W])
        );
        systolic_skew_mux #(
            .DATA_W(DATA_W), .N(N), .COL_MODE(1'b1), .STEP_W(STEP_W), .LANE_W(LANE_W)
        ) u_b_mux (
            .mat(b_lat), .step(mux_step), .lane(LANE_W'(i)), .operand(b_skew[i*DATA_W +: DATA_W])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            step           <= '0;
            flush_cnt      <= '0;
            a_lat          <= '0;
            b_lat          <= '0;
            bus.a_west     <= '0;
            bus.b_north    <= '0;
            bus.pe_clear   <= 1'b0;
            bus.feed_valid <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
        end else begin
            bus.pe_clear   <= 1'b0;
            bus.feed_valid <= 1'b0;
            bus.done       <= 1'b0;
            unique case (state)
                IDLE: if (bus.start) begin
                    a_lat        <= bus.a_mat;
                    b_lat        <= bus.b_mat;
                    state        <= LOAD;
                    bus.pe_clear <= 1'b1;
                    bus.busy     <= 1'b1;
                end
                LOAD: begin
                    state          <= FEED;
                    step           <= '0;
                    bus.a_west     <= a_skew;
                    bus.b_north    <= b_skew;
                    bus.feed_valid <= 1'b1;
                end
                // A stalled cycle holds state, counters and data; feed_valid drops.
                FEED: if (!bus.stall) begin
                    if (step == LAST_STEP) begin
                        bus.a_west  <= '0;
                        bus.b_north <= '0;
                        if (FLUSH_CYCLES == 0) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end else begin
                            state          <= FLUSH;
                            flush_cnt      <= '0;
                            bus.feed_valid <= 1'b1;
                        end
                    end else begin
                        step           <= step + 1'b1;
                        bus.a_west     <= a_skew;
                        bus.b_north    <= b_skew;
                        bus.feed_valid <= 1'b1;
                    end
                end
                FLUSH: if (!bus.stall) begin
                    if (flush_cnt == LAST_FLUSH) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                    end else begin
                        flush_cnt      <= flush_cnt + 1'b1;
                        bus.feed_valid <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
